// File: rtl/serial_parity_frame_rx.sv
// Bit-strobed serial frame receiver: start(0), DATA_W data bits LSB first, parity, stop(1).
// Presents the last good data word and its captured parity with a one-cycle frame_valid pulse.
module serial_parity_frame_rx #(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_out,
  output logic              frame_valid,
  output logic              framing_err,
  output logic              busy
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par_r, par_n;
  logic [DATA_W-1:0] data_n;
  logic              parity_n;
  logic              frame_valid_n;
  logic              framing_err_n;

  // Handshake: there is no back-pressure. frame_valid is a single-cycle pulse
  // meaning data_out/parity_out were updated on the edge that raised it; the
  // consumer must take the pair that cycle or rely on it holding until the next pulse.

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      par_r       <= 1'b0;
      data_out    <= '0;
      parity_out  <= 1'b0;
      frame_valid <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      par_r       <= par_n;
      data_out    <= data_n;
      parity_out  <= parity_n;
      frame_valid <= frame_valid_n;
      framing_err <= framing_err_n;
    end
  end

  // Pulses default low every cycle, so they drop on the next edge even without a strobe.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    shreg_n       = shreg;
    par_n         = par_r;
    data_n        = data_out;
    parity_n      = parity_out;
    frame_valid_n = 1'b0;
    framing_err_n = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!sin) begin
            state_n = DATA;
            cnt_n   = '0;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt == CW'(i)) shreg_n[i] = sin;
          end
          if (cnt == CW'(DATA_W - 1)) begin
            state_n = PAR;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        PAR: begin
          par_n   = sin;
          state_n = STOP;
        end
        STOP: begin
          // A low stop bit drops the frame; it is not treated as a new start bit.
          if (sin) begin
            data_n        = shreg;
            parity_n      = par_r;
            frame_valid_n = 1'b1;
          end else begin
            framing_err_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_frame_rx.sv
// Directed bench for serial_parity_frame_rx (DATA_W=3): expected frames are queued as
// they are sent and checked when frame_valid pulses.
module tb_serial_parity_frame_rx;

  localparam int DATA_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              sin;
  logic              bit_en;
  logic [DATA_W-1:0] data_out;
  logic              parity_out;
  logic              frame_valid;
  logic              framing_err;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;
  int fv_seen     = 0;
  int fe_seen     = 0;
  logic [DATA_W:0] exp_q[$];

  serial_parity_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .bit_en      (bit_en),
    .data_out    (data_out),
    .parity_out  (parity_out),
    .frame_valid (frame_valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (frame_valid === 1'b1) begin
      fv_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_valid", 8'd1, 8'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 8'(data_out), 8'(e[DATA_W-1:0]));
        chk("sb_parity", 8'(parity_out), 8'(e[DATA_W]));
      end
    end
    if (framing_err === 1'b1) fe_seen++;
  end

  task automatic send_bit(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      sin    = 1'($urandom_range(0, 1));
      bit_en = 1'b0;
      @(posedge clk);
      #1;
    end
    sin    = b;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    sin    = 1'b1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic stop,
                            input int gap);
    if (stop) exp_q.push_back({p, d});
    send_bit(1'b0, gap);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i], gap);
    send_bit(p, gap);
    send_bit(stop, gap);
  endtask

  initial begin
    // Reset held with an active strobe and low line: reset must win.
    rst    = 1'b1;
    sin    = 1'b0;
    bit_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 8'(data_out), 8'd0);
    chk("rst_parity", 8'(parity_out), 8'd0);
    chk("rst_fv", 8'(frame_valid), 8'd0);
    chk("rst_fe", 8'(framing_err), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    rst    = 1'b0;
    bit_en = 1'b0;
    sin    = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Continuous strobe: start, 1,0,1, parity 0, stop.
    exp_q.push_back({1'b0, 3'b101});
    send_bit(1'b0, 0);
    chk("t1_busy_after_start", 8'(busy), 8'd1);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    chk("t1_fv_before_stop", 8'(frame_valid), 8'd0);
    send_bit(1'b1, 0);
    chk("t1_fv_pulse", 8'(frame_valid), 8'd1);
    chk("t1_data", 8'(data_out), 8'h5);
    chk("t1_parity", 8'(parity_out), 8'd0);
    @(posedge clk);
    #1;
    chk("t1_fv_drop", 8'(frame_valid), 8'd0);
    chk("t1_idle", 8'(busy), 8'd0);

    // Same frame with a low stop bit: framing error, outputs hold.
    send_frame(3'b101, 1'b0, 1'b0, 0);
    chk("t2_fe_pulse", 8'(framing_err), 8'd1);
    chk("t2_fv", 8'(frame_valid), 8'd0);
    chk("t2_data_hold", 8'(data_out), 8'h5);
    chk("t2_parity_hold", 8'(parity_out), 8'd0);
    chk("t2_idle_after_err", 8'(busy), 8'd0);
    @(posedge clk);
    #1;
    chk("t2_fe_drop", 8'(framing_err), 8'd0);
    send_bit(1'b1, 0);
    chk("t2_no_false_start", 8'(busy), 8'd0);

    // Strobe every 4th cycle with random line noise between strobes.
    send_frame(3'b011, 1'b0, 1'b1, 3);
    chk("t3_fv_pulse", 8'(frame_valid), 8'd1);
    chk("t3_data", 8'(data_out), 8'h3);
    chk("t3_parity", 8'(parity_out), 8'd0);

    // Line low without strobes: no start, no pulses.
    sin    = 1'b0;
    bit_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t4_busy_low", 8'(busy), 8'd0);
    end
    sin = 1'b1;

    // Reset after d1 sampled: partial frame dropped, outputs cleared.
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    chk("t5_busy_mid", 8'(busy), 8'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_rst_data", 8'(data_out), 8'd0);
    chk("t5_rst_parity", 8'(parity_out), 8'd0);
    chk("t5_rst_busy", 8'(busy), 8'd0);
    chk("t5_rst_fv", 8'(frame_valid), 8'd0);
    send_frame(3'b111, 1'b1, 1'b1, $urandom_range(0, 2));
    chk("t5_data", 8'(data_out), 8'h7);
    chk("t5_parity", 8'(parity_out), 8'd1);

    // Back-to-back frames with no idle strobe between them.
    send_frame(3'b000, 1'b0, 1'b1, 0);
    chk("t6_f1_data", 8'(data_out), 8'h0);
    send_frame(3'b001, 1'b1, 1'b1, 0);
    chk("t6_f2_data", 8'(data_out), 8'h1);
    chk("t6_f2_parity", 8'(parity_out), 8'd1);

    repeat (4) @(posedge clk);
    #1;
    chk("end_queue_empty", 8'(exp_q.size()), 8'd0);
    chk("end_fv_count", 8'(fv_seen), 8'd5);
    chk("end_fe_count", 8'(fe_seen), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
